// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg: state encoding and defaults shared by the '165 reader and '595 driver.
package shiftreg_pkg;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_CLK_DIV = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SETTLE   = 3'd2,
        SHIFT_HI = 3'd3,
        SHIFT_LO = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};

endmodule

// File: rtl/shiftin_165.sv
// shiftin_165: reads a (chained) 74HC165 register: pulse /PL, then clock WIDTH bits in MSB first.
module shiftin_165
    import shiftreg_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             serial_i,
    output logic             sclk_o,
    output logic             pload_no,
    output logic [WIDTH-1:0] data_o,
    output logic             data_valid_o,
    output logic             busy_o
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = $clog2(CLK_DIV);

    state_t           state, state_n;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt, bit_cnt_inc;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic             serial_sync, start_armed, start_edge, phase_end, sample;

    sync_2ff u_sync (
        .clk (clk_i),
        .rst (reset_i),
        .d   (serial_i),
        .q   (serial_sync)
    );

    // Armed only after start_i has been seen low, so a level held through reset cannot start a frame.
    assign start_edge  = start_i & start_armed;
    assign phase_end   = div_cnt == DW'(CLK_DIV - 1);
    assign sample      = phase_end && (state == SETTLE || state == SHIFT_LO);
    assign bit_cnt_inc = bit_cnt + 1'b1;
    assign shift_nxt   = {shift_reg[WIDTH-2:0], serial_sync};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (start_edge) state_n = LOAD;
            LOAD:     if (phase_end) state_n = SETTLE;
            SETTLE:   if (phase_end) state_n = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_n = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_n = (bit_cnt_inc == BW'(WIDTH)) ? DONE : SHIFT_HI;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the board-level pins never glitch.
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) begin
            state        <= IDLE;
            start_armed  <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            busy_o       <= 1'b0;
            sclk_o       <= 1'b0;
            pload_no     <= 1'b1;
        end else begin
            state        <= state_n;
            start_armed  <= ~start_i;
            div_cnt      <= (state inside {IDLE, DONE} || phase_end) ? '0 : div_cnt + 1'b1;
            bit_cnt      <= (state == IDLE) ? '0 : sample ? bit_cnt_inc : bit_cnt;
            if (sample) shift_reg <= shift_nxt;
            if (state_n == DONE) data_o <= shift_nxt;
            data_valid_o <= state_n == DONE;
            busy_o       <= state_n != IDLE;
            sclk_o       <= state_n == SHIFT_HI;
            pload_no     <= state_n != LOAD;
        end

endmodule

// File: tb/tb_shiftin_165.sv
// tb_shiftin_165: directed bench with behavioural '165 models for a 16-bit/div-4 and an 8-bit/div-3 reader.
module tb_shiftin_165;

    logic clk = 0;
    always #5 clk = ~clk;

    logic rst16 = 0, start16 = 0, ser16, sclk16, pl16, dv16, busy16;
    logic rst8 = 0, start8 = 0, ser8, sclk8, pl8, dv8, busy8;
    logic [15:0] q16, m16_par = '0, m16_sr = '0;
    logic [7:0]  q8, m8_par = '0, m8_sr = '0;
    int tests = 0, errs = 0, r16 = 0, r8 = 0, vcnt16 = 0;

    shiftin_165 dut16 (
        .clk_i(clk), .reset_i(rst16), .start_i(start16), .serial_i(ser16), .sclk_o(sclk16),
        .pload_no(pl16), .data_o(q16), .data_valid_o(dv16), .busy_o(busy16)
    );

    shiftin_165 #(.WIDTH(8), .CLK_DIV(3)) dut8 (
        .clk_i(clk), .reset_i(rst8), .start_i(start8), .serial_i(ser8), .sclk_o(sclk8),
        .pload_no(pl8), .data_o(q8), .data_valid_o(dv8), .busy_o(busy8)
    );

    // '165 models: load on /PL falling, shift toward Q7 on CP rising, DS tied low
    always @(posedge sclk16 or negedge pl16)
        if (!pl16) m16_sr = m16_par;
        else begin m16_sr = {m16_sr[14:0], 1'b0}; r16++; end
    always @(posedge sclk8 or negedge pl8)
        if (!pl8) m8_sr = m8_par;
        else begin m8_sr = {m8_sr[6:0], 1'b0}; r8++; end
    assign ser16 = m16_sr[15];
    assign ser8  = m8_sr[7];
    always @(posedge clk) if (dv16) vcnt16++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame from the current cycle (cycle 0) through cycle last+1; ra/rb re-pulse start.
    task automatic frame(input bit s, input logic [15:0] pat, input int ra, input int rb, input string nm);
        int d = s ? 3 : 4;
        int w = s ? 8 : 16;
        int last = 2 * d * w + 1;
        int pl_first = -1, pl_last = -1, pl_n = 0, v_n = 0, v_at = -1, r0;
        logic [15:0] got = '0;
        bit busy_ok = 1;
        if (s) begin m8_par = pat[7:0]; start8 = 1; end
        else begin m16_par = pat; start16 = 1; end
        r0 = s ? r8 : r16;
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            if (s) start8 = 0; else start16 = (c == ra || c == rb);
            if (s && c == d + 1) m8_par = 8'h7E;
            if (!(s ? pl8 : pl16)) begin
                pl_n++;
                if (pl_first < 0) pl_first = c;
                pl_last = c;
            end
            if (s ? dv8 : dv16) begin
                v_n++;
                v_at = c;
                got = s ? {8'h00, q8} : q16;
            end
            if (c <= last && !(s ? busy8 : busy16)) busy_ok = 0;
        end
        check({nm, " pload first"}, pl_first, 1);
        check({nm, " pload last"}, pl_last, d);
        check({nm, " pload count"}, pl_n, d);
        check({nm, " sclk rises"}, (s ? r8 : r16) - r0, w - 1);
        check({nm, " valid count"}, v_n, 1);
        check({nm, " valid cycle"}, v_at, last);
        check({nm, " data"}, got, s ? {8'h00, pat[7:0]} : pat);
        check({nm, " busy held"}, busy_ok, 1);
        check({nm, " busy dropped"}, s ? busy8 : busy16, 0);
    endtask

    initial begin
        int v0;
        tick();
        start16 = 1; start8 = 1; rst16 = 1; rst8 = 1;
        tick(); tick();
        check("rst sclk", sclk16, 0);
        check("rst pload", pl16, 1);
        check("rst data", q16, 0);
        check("rst valid", dv16, 0);
        check("rst busy", busy16, 0);
        check("rst8 pload", pl8, 1);
        rst16 = 0; rst8 = 0;
        repeat (10) tick();
        check("held start no frame", busy16, 0);
        check("held start no frame8", busy8, 0);
        start16 = 0; start8 = 0;
        tick();

        frame(0, 16'hA5C3, 0, 0, "t2");
        frame(0, 16'h0000, 0, 0, "t3a");
        frame(0, 16'hFFFF, 0, 0, "t3b");
        tick();
        frame(0, 16'h3C96, 20, 100, "t4");

        tick();
        m16_par = 16'hBEEF;
        start16 = 1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start16 = 0;
        end
        v0 = vcnt16;
        rst16 = 1;
        #1;
        check("t5 sclk", sclk16, 0);
        check("t5 pload", pl16, 1);
        check("t5 busy", busy16, 0);
        check("t5 data", q16, 0);
        tick();
        rst16 = 0;
        repeat (150) tick();
        check("t5 no valid", vcnt16 - v0, 0);
        check("t5 idle", busy16, 0);
        frame(0, 16'h1234, 0, 0, "t5");

        tick();
        frame(1, 16'h0081, 0, 0, "t6");

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
